// File: rtl/inst_mem_arbiter_if.sv
// Handshake bundle between the fetch arbiter, the per-core fetchers and instruction memory.
// The arbiter uses the slave modport; the environment driving it uses master.
interface inst_mem_arbiter_if #(
  parameter int NUM_CORES    = 4,
  parameter int NUM_CHANNELS = 2,
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 16,
  parameter int OW           = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
);
  logic [NUM_CORES-1:0]               fetch_req_val;
  logic [NUM_CORES-1:0]               fetch_req_rdy;
  logic [NUM_CORES*ADDR_WIDTH-1:0]    fetch_req_addr;
  logic [NUM_CORES-1:0]               fetch_resp_val;
  logic [NUM_CORES-1:0]               fetch_resp_rdy;
  logic [NUM_CORES*DATA_WIDTH-1:0]    fetch_resp_data;
  logic [NUM_CHANNELS-1:0]            mem_req_val;
  logic [NUM_CHANNELS-1:0]            mem_req_rdy;
  logic [NUM_CHANNELS*ADDR_WIDTH-1:0] mem_req_addr;
  logic [NUM_CHANNELS-1:0]            mem_resp_val;
  logic [NUM_CHANNELS-1:0]            mem_resp_rdy;
  logic [NUM_CHANNELS*DATA_WIDTH-1:0] mem_resp_data;
  logic [NUM_CHANNELS-1:0]            chan_busy;
  logic [NUM_CHANNELS*OW-1:0]         chan_owner;

  modport slave (
    input  fetch_req_val, fetch_req_addr, fetch_resp_rdy,
           mem_req_rdy, mem_resp_val, mem_resp_data,
    output fetch_req_rdy, fetch_resp_val, fetch_resp_data,
           mem_req_val, mem_req_addr, mem_resp_rdy, chan_busy, chan_owner
  );

  modport master (
    output fetch_req_val, fetch_req_addr, fetch_resp_rdy,
           mem_req_rdy, mem_resp_val, mem_resp_data,
    input  fetch_req_rdy, fetch_resp_val, fetch_resp_data,
           mem_req_val, mem_req_addr, mem_resp_rdy, chan_busy, chan_owner
  );
endinterface

// File: rtl/inst_mem_arbiter.sv
// Round-robin instruction-fetch arbiter: NUM_CORES fetchers onto NUM_CHANNELS memory channels,
// one outstanding request per channel and per core, responses routed back to the issuing core.
//
// state   | meaning
// IDLE    | channel free, may be granted this cycle
// REQ     | presenting latched address to memory
// WAIT    | request accepted, waiting for memory data
// RESP    | holding data for the owning core until it is consumed
module inst_mem_arbiter #(
  parameter int NUM_CORES    = 4,
  parameter int NUM_CHANNELS = 2,
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 16,
  parameter int OW           = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic               clk,
  input  logic               reset,
  inst_mem_arbiter_if.slave  bus
);
  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_RESP} chan_state_t;

  chan_state_t           state_q [NUM_CHANNELS];
  chan_state_t           state_d [NUM_CHANNELS];
  logic [OW-1:0]         owner_q [NUM_CHANNELS];
  logic [OW-1:0]         owner_d [NUM_CHANNELS];
  logic [ADDR_WIDTH-1:0] addr_q  [NUM_CHANNELS];
  logic [ADDR_WIDTH-1:0] addr_d  [NUM_CHANNELS];
  logic [DATA_WIDTH-1:0] data_q  [NUM_CHANNELS];
  logic [DATA_WIDTH-1:0] data_d  [NUM_CHANNELS];
  logic [OW-1:0]         rr_ptr_q, rr_ptr_d;

  logic [NUM_CORES-1:0]    core_busy, eligible, req_rdy;
  logic [NUM_CHANNELS-1:0] chan_grant;
  logic [OW-1:0]           grant_owner [NUM_CHANNELS];
  int                      idle_list   [NUM_CHANNELS];
  int                      num_idle, grant_k, scan_core;

  always_comb begin
    core_busy = '0;
    for (int ch = 0; ch < NUM_CHANNELS; ch++)
      if (state_q[ch] != ST_IDLE) core_busy[owner_q[ch]] = 1'b1;
  end

  // Gating with reset keeps every output at zero while reset is held.
  assign eligible = bus.fetch_req_val & ~core_busy & {NUM_CORES{~reset}};

  // k-th eligible core in scan order from rr_ptr pairs with the k-th idle channel.
  always_comb begin
    num_idle   = 0;
    grant_k    = 0;
    scan_core  = 0;
    req_rdy    = '0;
    chan_grant = '0;
    rr_ptr_d   = rr_ptr_q;
    for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
      idle_list[ch]   = 0;
      grant_owner[ch] = '0;
    end
    for (int ch = 0; ch < NUM_CHANNELS; ch++)
      if (state_q[ch] == ST_IDLE) begin
        idle_list[num_idle] = ch;
        num_idle++;
      end
    for (int i = 0; i < NUM_CORES; i++) begin
      scan_core = (int'(rr_ptr_q) + i) % NUM_CORES;
      if (eligible[scan_core] && grant_k < num_idle) begin
        req_rdy[scan_core]                = 1'b1;
        chan_grant[idle_list[grant_k]]    = 1'b1;
        grant_owner[idle_list[grant_k]]   = OW'(scan_core);
        grant_k++;
        rr_ptr_d = OW'((scan_core + 1) % NUM_CORES);
      end
    end
  end

  always_comb begin
    for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
      state_d[ch] = state_q[ch];
      owner_d[ch] = owner_q[ch];
      addr_d[ch]  = addr_q[ch];
      data_d[ch]  = data_q[ch];
      case (state_q[ch])
        ST_IDLE: if (chan_grant[ch]) begin
          state_d[ch] = ST_REQ;
          owner_d[ch] = grant_owner[ch];
          addr_d[ch]  = bus.fetch_req_addr[int'(grant_owner[ch])*ADDR_WIDTH +: ADDR_WIDTH];
        end
        ST_REQ:  if (bus.mem_req_rdy[ch]) state_d[ch] = ST_WAIT;
        ST_WAIT: if (bus.mem_resp_val[ch]) begin
          state_d[ch] = ST_RESP;
          data_d[ch]  = bus.mem_resp_data[ch*DATA_WIDTH +: DATA_WIDTH];
        end
        ST_RESP: if (bus.fetch_resp_rdy[owner_q[ch]]) begin
          state_d[ch] = ST_IDLE;
          owner_d[ch] = '0;
          data_d[ch]  = '0;
        end
        default: state_d[ch] = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q <= '0;
      for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
        state_q[ch] <= ST_IDLE;
        owner_q[ch] <= '0;
        addr_q[ch]  <= '0;
        data_q[ch]  <= '0;
      end
    end else begin
      rr_ptr_q <= rr_ptr_d;
      for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
        state_q[ch] <= state_d[ch];
        owner_q[ch] <= owner_d[ch];
        addr_q[ch]  <= addr_d[ch];
        data_q[ch]  <= data_d[ch];
      end
    end
  end

  always_comb begin
    bus.fetch_req_rdy   = req_rdy;
    bus.fetch_resp_val  = '0;
    bus.fetch_resp_data = '0;
    bus.mem_req_val     = '0;
    bus.mem_req_addr    = '0;
    bus.mem_resp_rdy    = '0;
    bus.chan_busy       = '0;
    bus.chan_owner      = '0;
    for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
      bus.mem_req_val[ch]  = (state_q[ch] == ST_REQ);
      bus.mem_resp_rdy[ch] = (state_q[ch] == ST_WAIT);
      bus.chan_busy[ch]    = (state_q[ch] != ST_IDLE);
      bus.chan_owner[ch*OW +: OW] = owner_q[ch];
      if (state_q[ch] == ST_REQ)
        bus.mem_req_addr[ch*ADDR_WIDTH +: ADDR_WIDTH] = addr_q[ch];
      if (state_q[ch] == ST_RESP) begin
        bus.fetch_resp_val[owner_q[ch]] = 1'b1;
        bus.fetch_resp_data[int'(owner_q[ch])*DATA_WIDTH +: DATA_WIDTH] = data_q[ch];
      end
    end
  end
endmodule

// File: tb/tb_inst_mem_arbiter.sv
// Directed bench for inst_mem_arbiter (4 cores, 2 channels): latency, fairness, stalls,
// out-of-order completion, busy-core blocking and mid-flight reset.
module tb_inst_mem_arbiter;
  localparam int NC = 4, NCH = 2, AW = 8, DW = 16;

  logic clk;
  logic reset;
  int   tests_run = 0;
  int   tests_failed = 0;
  int   gcount [NC];
  int   resp_count;
  logic [NC-1:0] exp_rdy;

  inst_mem_arbiter_if #(.NUM_CORES(NC), .NUM_CHANNELS(NCH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  inst_mem_arbiter #(.NUM_CORES(NC), .NUM_CHANNELS(NCH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    reset = 1'b1;
    bus.fetch_req_val  = '0;
    bus.fetch_req_addr = '0;
    bus.fetch_resp_rdy = '0;
    bus.mem_req_rdy    = '0;
    bus.mem_resp_val   = '0;
    bus.mem_resp_data  = '0;
    cyc();
    cyc();
    // Requests held during reset must not be acknowledged.
    bus.fetch_req_val = 4'hF;
    settle();
    check("rst_req_rdy",    bus.fetch_req_rdy, 0);
    check("rst_busy",       bus.chan_busy, 0);
    check("rst_mem_val",    bus.mem_req_val, 0);
    check("rst_mem_addr",   bus.mem_req_addr, 0);
    check("rst_resp_rdy",   bus.mem_resp_rdy, 0);
    check("rst_fresp_val",  bus.fetch_resp_val, 0);
    check("rst_fresp_data", bus.fetch_resp_data, 0);
    check("rst_owner",      bus.chan_owner, 0);
    bus.fetch_req_val = '0;
    reset = 1'b0;
    cyc();

    // Single request, best-case latency
    bus.mem_req_rdy    = 2'b11;
    bus.mem_resp_val   = 2'b11;
    bus.mem_resp_data  = {16'hBEEF, 16'hBEEF};
    bus.fetch_resp_rdy = 4'hF;
    bus.fetch_req_addr = 32'h003C_0000;
    bus.fetch_req_val  = 4'b0100;
    settle();
    check("t1_grant", bus.fetch_req_rdy, 4'b0100);
    cyc();
    bus.fetch_req_val = '0;
    settle();
    check("t1_mem_val",  bus.mem_req_val, 2'b01);
    check("t1_mem_addr", bus.mem_req_addr, 16'h003C);
    check("t1_owner",    bus.chan_owner, 4'h2);
    cyc(); settle();
    check("t1_wait_val", bus.mem_req_val, 0);
    check("t1_wait_rdy", bus.mem_resp_rdy, 2'b01);
    cyc(); settle();
    check("t1_resp_val",  bus.fetch_resp_val, 4'b0100);
    check("t1_resp_data", bus.fetch_resp_data, 64'h0000_BEEF_0000_0000);
    cyc(); settle();
    check("t1_idle_busy", bus.chan_busy, 0);
    check("t1_idle_resp", bus.fetch_resp_val, 0);

    // Fairness: all cores request continuously from a fresh rr pointer
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    bus.fetch_req_addr = 32'h4030_2010;
    bus.fetch_req_val  = 4'hF;
    for (int c = 0; c < NC; c++) gcount[c] = 0;
    for (int i = 0; i < 64; i++) begin
      settle();
      if (i % 4 != 0)            exp_rdy = 4'b0000;
      else if ((i / 4) % 2 == 0) exp_rdy = 4'b0011;
      else                       exp_rdy = 4'b1100;
      check("rr_rdy", bus.fetch_req_rdy, exp_rdy);
      for (int c = 0; c < NC; c++)
        if (bus.fetch_req_rdy[c] && bus.fetch_req_val[c]) gcount[c]++;
      if (i == 1) check("rr_owner_a", bus.chan_owner, 4'b0100);
      if (i == 5) check("rr_owner_b", bus.chan_owner, 4'b1110);
      cyc();
    end
    bus.fetch_req_val = '0;
    for (int c = 0; c < NC; c++) check("rr_count", gcount[c], 8);
    cyc(); cyc(); cyc(); cyc();
    settle();
    check("rr_drain", bus.chan_busy, 0);

    // Stalls on every handshake; core 1 lands on ch0 (rr pointer at 0)
    bus.mem_req_rdy    = '0;
    bus.mem_resp_val   = '0;
    bus.fetch_resp_rdy = '0;
    bus.mem_resp_data  = {16'h1234, 16'h1234};
    bus.fetch_req_addr = 32'h0000_5500;
    bus.fetch_req_val  = 4'b0010;
    resp_count = 0;
    settle();
    check("st_grant", bus.fetch_req_rdy, 4'b0010);
    cyc();
    bus.fetch_req_val = '0;
    for (int i = 0; i < 5; i++) begin
      settle();
      check("st_req_val",  bus.mem_req_val, 2'b01);
      check("st_req_addr", bus.mem_req_addr, 16'h0055);
      cyc();
    end
    bus.mem_req_rdy = 2'b01;
    settle();
    check("st_req_acc", bus.mem_req_val, 2'b01);
    cyc();
    bus.mem_req_rdy = '0;
    for (int i = 0; i < 3; i++) begin
      settle();
      check("st_wait_rdy", bus.mem_resp_rdy, 2'b01);
      check("st_wait_req", bus.mem_req_val, 0);
      check("st_wait_out", bus.fetch_resp_val, 0);
      cyc();
    end
    bus.mem_resp_val = 2'b01;
    settle();
    check("st_wait_acc", bus.mem_resp_rdy, 2'b01);
    cyc();
    bus.mem_resp_val  = '0;
    bus.mem_resp_data = {16'hFFFF, 16'hFFFF};
    for (int i = 0; i < 4; i++) begin
      settle();
      check("st_resp_val",  bus.fetch_resp_val, 4'b0010);
      check("st_resp_data", bus.fetch_resp_data, 64'h0000_0000_1234_0000);
      if (bus.fetch_resp_val[1] && bus.fetch_resp_rdy[1]) resp_count++;
      cyc();
    end
    bus.fetch_resp_rdy = 4'b0010;
    settle();
    check("st_resp_acc", bus.fetch_resp_val, 4'b0010);
    if (bus.fetch_resp_val[1] && bus.fetch_resp_rdy[1]) resp_count++;
    cyc();
    settle();
    if (bus.fetch_resp_val[1] && bus.fetch_resp_rdy[1]) resp_count++;
    check("st_after_val",  bus.fetch_resp_val, 0);
    check("st_after_busy", bus.chan_busy, 0);
    check("st_resp_count", resp_count, 1);

    // Out-of-order completion: rr pointer at 2, core 2 -> ch0, core 3 -> ch1
    bus.fetch_resp_rdy = 4'hF;
    bus.mem_req_rdy    = 2'b11;
    bus.mem_resp_val   = '0;
    bus.fetch_req_addr = 32'h2010_0000;
    bus.fetch_req_val  = 4'b1100;
    settle();
    check("oo_grant", bus.fetch_req_rdy, 4'b1100);
    cyc();
    bus.fetch_req_val = '0;
    settle();
    check("oo_addr",  bus.mem_req_addr, 16'h2010);
    check("oo_owner", bus.chan_owner, 4'b1110);
    cyc();
    bus.mem_resp_val  = 2'b10;
    bus.mem_resp_data = {16'hA020, 16'h0000};
    settle();
    check("oo_wait", bus.mem_resp_rdy, 2'b11);
    cyc();
    bus.mem_resp_val  = 2'b01;
    bus.mem_resp_data = {16'h0000, 16'hA010};
    settle();
    check("oo_first_val",  bus.fetch_resp_val, 4'b1000);
    check("oo_first_data", bus.fetch_resp_data, 64'hA020_0000_0000_0000);
    cyc();
    bus.mem_resp_val = '0;
    settle();
    check("oo_second_val",  bus.fetch_resp_val, 4'b0100);
    check("oo_second_data", bus.fetch_resp_data, 64'h0000_A010_0000_0000);
    check("oo_second_busy", bus.chan_busy, 2'b01);
    cyc(); settle();
    check("oo_idle", bus.chan_busy, 0);

    // Busy-core blocking: core 0 holds its request; rr pointer at 0
    bus.mem_req_rdy    = 2'b11;
    bus.mem_resp_val   = 2'b11;
    bus.mem_resp_data  = {16'h5555, 16'h5555};
    bus.fetch_resp_rdy = '0;
    bus.fetch_req_addr = 32'h0000_0077;
    bus.fetch_req_val  = 4'b0001;
    settle();
    check("bz_grant", bus.fetch_req_rdy, 4'b0001);
    cyc(); settle();
    check("bz_req_rdy", bus.fetch_req_rdy, 0);
    check("bz_req_busy", bus.chan_busy, 2'b01);
    cyc(); settle();
    check("bz_wait_rdy", bus.fetch_req_rdy, 0);
    check("bz_wait_busy", bus.chan_busy, 2'b01);
    cyc(); settle();
    check("bz_resp_rdy", bus.fetch_req_rdy, 0);
    check("bz_resp_val", bus.fetch_resp_val, 4'b0001);
    check("bz_resp_busy", bus.chan_busy, 2'b01);
    cyc();
    bus.fetch_resp_rdy = 4'b0001;
    settle();
    check("bz_consume_rdy", bus.fetch_req_rdy, 0);
    check("bz_consume_busy", bus.chan_busy, 2'b01);
    cyc(); settle();
    check("bz_regrant", bus.fetch_req_rdy, 4'b0001);
    check("bz_regrant_busy", bus.chan_busy, 0);
    cyc();
    bus.fetch_req_val = '0;
    cyc(); cyc(); cyc();
    settle();
    check("bz_drain", bus.chan_busy, 0);

    // Reset while ch0 waits for memory; late data must be dropped. rr pointer at 1.
    bus.fetch_resp_rdy = 4'hF;
    bus.mem_req_rdy    = 2'b11;
    bus.mem_resp_val   = '0;
    bus.fetch_req_addr = 32'h0000_4200;
    bus.fetch_req_val  = 4'b0010;
    settle();
    check("rs_grant", bus.fetch_req_rdy, 4'b0010);
    cyc();
    bus.fetch_req_val = '0;
    settle();
    check("rs_req", bus.mem_req_val, 2'b01);
    cyc(); settle();
    check("rs_wait", bus.mem_resp_rdy, 2'b01);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    settle();
    check("rs_busy",     bus.chan_busy, 0);
    check("rs_resp_rdy", bus.mem_resp_rdy, 0);
    check("rs_mem_val",  bus.mem_req_val, 0);
    check("rs_mem_addr", bus.mem_req_addr, 0);
    check("rs_fresp",    bus.fetch_resp_val, 0);
    check("rs_fdata",    bus.fetch_resp_data, 0);
    check("rs_owner",    bus.chan_owner, 0);
    bus.mem_resp_val  = 2'b01;
    bus.mem_resp_data = {16'hDEAD, 16'hDEAD};
    for (int i = 0; i < 3; i++) begin
      cyc(); settle();
      check("rs_late_fresp", bus.fetch_resp_val, 0);
      check("rs_late_rdy",   bus.mem_resp_rdy, 0);
    end
    bus.mem_resp_val = '0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
